vending_core_multi: RTL and testbench

Parametrised vending-machine core that supersedes the single-product controller path. It holds a writable price table and per-product stock counters. It accumulates coin credit, arbitrates confirm, cancel, timeout and open/closed events in one FSM, and emits dispense, change and alarm events plus a saturating sales total. It sits between the coin/product decoders and the seven-segment display modules; `credit`, `change_amount` and `sales_total` feed the displays directly.

---
 rtl/vending_core_multi.sv | 240 ++++++++++++++++++++++++
 tb/tb_vending_core_multi.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_core_multi.sv
// Multi-product vending core: price table, per-product stock, coin credit, alarm/timeout
// handling and a saturating sales total. Every output is driven straight from a register.
module vending_core_multi #(
  parameter int unsigned N_PROD       = 8,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned VAL_W        = 8,
  parameter int unsigned SALES_W      = 16,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned INIT_STOCK   = 5,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned ALARM_CYCLES = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               open_in,
  input  logic               coin_valid,
  input  logic [VAL_W-1:0]   coin_value,
  input  logic [SEL_W-1:0]   sel,
  input  logic               confirm,
  input  logic               cancel,
  input  logic               price_we,
  input  logic [SEL_W-1:0]   price_addr,
  input  logic [VAL_W-1:0]   price_data,
  input  logic               restock,
  input  logic [SEL_W-1:0]   restock_addr,
  input  logic               sales_clear,
  output logic [VAL_W-1:0]   credit,
  output logic               coin_reject,
  output logic               dispense_valid,
  output logic [SEL_W-1:0]   dispense_id,
  output logic               change_valid,
  output logic [VAL_W-1:0]   change_amount,
  output logic               alarm,
  output logic [1:0]         alarm_code,
  output logic [SALES_W-1:0] sales_total,
  output logic [2:0]         state
);

  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned AlmW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  // Debug encoding on `state`: 0 closed, 1 idle, 2 credit, 3 dispense, 4 alarm.
  typedef enum logic [2:0] {
    StClosed   = 3'd0,
    StIdle     = 3'd1,
    StCredit   = 3'd2,
    StDispense = 3'd3,
    StAlarm    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [VAL_W-1:0]     credit_q, credit_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 dispense_valid_q, dispense_valid_d;
  logic [SEL_W-1:0]     dispense_id_q, dispense_id_d;
  logic                 change_valid_q, change_valid_d;
  logic [VAL_W-1:0]     change_amount_q, change_amount_d;
  logic                 alarm_q, alarm_d;
  logic [1:0]           alarm_code_q, alarm_code_d;
  logic [AlmW-1:0]      alarm_cnt_q, alarm_cnt_d;
  logic [TmrW-1:0]      timer_q, timer_d;
  logic [SALES_W-1:0]   sales_q, sales_d;
  logic [VAL_W-1:0]     price_q [N_PROD];
  logic [STOCK_W-1:0]   stock_q [N_PROD];
  logic [STOCK_W-1:0]   stock_d [N_PROD];

  logic                 sel_ok, price_ok, restock_ok;
  logic [VAL_W-1:0]     sel_price;
  logic [STOCK_W-1:0]   sel_stock;
  logic [VAL_W:0]       coin_sum;
  logic [SALES_W:0]     sales_sum;
  logic                 timeout_hit, coin_ok, refund, sell, raise;
  logic [1:0]           raise_code;

  assign sel_ok      = 32'(sel) < N_PROD;
  assign price_ok    = 32'(price_addr) < N_PROD;
  assign restock_ok  = 32'(restock_addr) < N_PROD;
  assign sel_price   = sel_ok ? price_q[sel] : '0;
  assign sel_stock   = sel_ok ? stock_q[sel] : '0;
  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_value};
  assign sales_sum   = {1'b0, sales_q} + {{(SALES_W + 1 - VAL_W){1'b0}}, sel_price};
  assign timeout_hit = (state_q == StCredit) && (timer_q == TmrW'(TIMEOUT - 1));

  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    dispense_valid_d = 1'b0;
    dispense_id_d    = dispense_id_q;
    change_valid_d   = 1'b0;
    change_amount_d  = change_amount_q;
    alarm_d          = alarm_q;
    alarm_code_d     = alarm_code_q;
    alarm_cnt_d      = alarm_cnt_q;
    timer_d          = '0;
    coin_ok          = 1'b0;
    refund           = 1'b0;
    sell             = 1'b0;
    raise            = 1'b0;
    raise_code       = 2'd0;

    unique case (state_q)
      StClosed: begin
        if (open_in) state_d = StIdle;
      end
      StIdle, StCredit: begin
        if (!open_in) begin
          refund  = 1'b1;
          state_d = StClosed;
        end else if (cancel || timeout_hit) begin
          refund  = 1'b1;
          state_d = StIdle;
        end else if (confirm) begin
          if (!sel_ok || sel_price == '0) begin
            raise      = 1'b1;
            raise_code = 2'd1;
          end else if (sel_stock == '0) begin
            raise      = 1'b1;
            raise_code = 2'd2;
          end else if (credit_q < sel_price) begin
            raise      = 1'b1;
            raise_code = 2'd3;
          end else begin
            sell             = 1'b1;
            state_d          = StDispense;
            dispense_valid_d = 1'b1;
            dispense_id_d    = sel;
            change_valid_d   = 1'b1;
            change_amount_d  = credit_q - sel_price;
            credit_d         = '0;
          end
        end else if (coin_valid && !coin_sum[VAL_W]) begin
          coin_ok  = 1'b1;
          credit_d = coin_sum[VAL_W-1:0];
          state_d  = StCredit;
        end else if (state_q == StCredit) begin
          // Overflowing coins are not accepted, so they do not restart the idle timer.
          timer_d = timer_q + 1'b1;
        end
      end
      StDispense: begin
        state_d = open_in ? StIdle : StClosed;
      end
      StAlarm: begin
        if (!open_in) begin
          refund  = 1'b1;
          alarm_d = 1'b0;
          state_d = StClosed;
        end else if (cancel) begin
          refund  = 1'b1;
          alarm_d = 1'b0;
          state_d = StIdle;
        end else if (alarm_cnt_q == '0) begin
          alarm_d = 1'b0;
          state_d = (credit_q != '0) ? StCredit : StIdle;
        end else begin
          alarm_cnt_d = alarm_cnt_q - 1'b1;
        end
      end
      default: state_d = StClosed;
    endcase

    if (raise) begin
      state_d      = StAlarm;
      alarm_d      = 1'b1;
      alarm_code_d = raise_code;
      alarm_cnt_d  = AlmW'(ALARM_CYCLES - 1);
    end

    if (refund) begin
      credit_d = '0;
      if (credit_q != '0) begin
        change_valid_d  = 1'b1;
        change_amount_d = credit_q;
      end
    end

    coin_reject_d = coin_valid && !coin_ok;

    if (sales_clear) begin
      sales_d = '0;
    end else if (sell) begin
      sales_d = sales_sum[SALES_W] ? '1 : sales_sum[SALES_W-1:0];
    end else begin
      sales_d = sales_q;
    end
  end

  // Restock is applied last so it overrides a decrement on the same address.
  always_comb begin
    stock_d = stock_q;
    if (sell) stock_d[sel] = sel_stock - 1'b1;
    if (restock && restock_ok) stock_d[restock_addr] = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StClosed;
      credit_q         <= '0;
      coin_reject_q    <= 1'b0;
      dispense_valid_q <= 1'b0;
      dispense_id_q    <= '0;
      change_valid_q   <= 1'b0;
      change_amount_q  <= '0;
      alarm_q          <= 1'b0;
      alarm_code_q     <= 2'd0;
      alarm_cnt_q      <= '0;
      timer_q          <= '0;
      sales_q          <= '0;
      price_q          <= '{default: '0};
      stock_q          <= '{default: STOCK_W'(INIT_STOCK)};
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      coin_reject_q    <= coin_reject_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_id_q    <= dispense_id_d;
      change_valid_q   <= change_valid_d;
      change_amount_q  <= change_amount_d;
      alarm_q          <= alarm_d;
      alarm_code_q     <= alarm_code_d;
      alarm_cnt_q      <= alarm_cnt_d;
      timer_q          <= timer_d;
      sales_q          <= sales_d;
      stock_q          <= stock_d;
      if (price_we && price_ok) price_q[price_addr] <= price_data;
    end
  end

  assign credit         = credit_q;
  assign coin_reject    = coin_reject_q;
  assign dispense_valid = dispense_valid_q;
  assign dispense_id    = dispense_id_q;
  assign change_valid   = change_valid_q;
  assign change_amount  = change_amount_q;
  assign alarm          = alarm_q;
  assign alarm_code     = alarm_code_q;
  assign sales_total    = sales_q;
  assign state          = state_q;

endmodule

// File: tb/tb_vending_core_multi.sv
// Bench for vending_core_multi: directed scenarios with literal expectations, then random
// traffic, all compared each cycle against an event-level model of the machine.
module tb_vending_core_multi;

  localparam int N_PROD       = 6;
  localparam int SEL_W        = 3;
  localparam int VAL_W        = 8;
  localparam int SALES_W      = 8;
  localparam int STOCK_W      = 4;
  localparam int INIT_STOCK   = 5;
  localparam int TIMEOUT      = 1000;
  localparam int ALARM_CYCLES = 50;
  localparam int VMAX         = 255;
  localparam int SMAX         = 255;
  localparam int STOCK_MAX    = 15;
  localparam int S_CLOSED = 0, S_IDLE = 1, S_CREDIT = 2, S_DISP = 3, S_ALARM = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               open_in = 1'b0;
  logic               coin_valid = 1'b0;
  logic [VAL_W-1:0]   coin_value = '0;
  logic [SEL_W-1:0]   sel = '0;
  logic               confirm = 1'b0;
  logic               cancel = 1'b0;
  logic               price_we = 1'b0;
  logic [SEL_W-1:0]   price_addr = '0;
  logic [VAL_W-1:0]   price_data = '0;
  logic               restock = 1'b0;
  logic [SEL_W-1:0]   restock_addr = '0;
  logic               sales_clear = 1'b0;
  logic [VAL_W-1:0]   credit;
  logic               coin_reject;
  logic               dispense_valid;
  logic [SEL_W-1:0]   dispense_id;
  logic               change_valid;
  logic [VAL_W-1:0]   change_amount;
  logic               alarm;
  logic [1:0]         alarm_code;
  logic [SALES_W-1:0] sales_total;
  logic [2:0]         state;

  vending_core_multi #(
    .N_PROD(N_PROD), .SEL_W(SEL_W), .VAL_W(VAL_W), .SALES_W(SALES_W), .STOCK_W(STOCK_W),
    .INIT_STOCK(INIT_STOCK), .TIMEOUT(TIMEOUT), .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .open_in(open_in), .coin_valid(coin_valid),
    .coin_value(coin_value), .sel(sel), .confirm(confirm), .cancel(cancel),
    .price_we(price_we), .price_addr(price_addr), .price_data(price_data),
    .restock(restock), .restock_addr(restock_addr), .sales_clear(sales_clear),
    .credit(credit), .coin_reject(coin_reject), .dispense_valid(dispense_valid),
    .dispense_id(dispense_id), .change_valid(change_valid), .change_amount(change_amount),
    .alarm(alarm), .alarm_code(alarm_code), .sales_total(sales_total), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Event-level model: money as plain ints, alarm as "high cycles left", idle time as a count.
  int m_state, m_credit, m_sales, m_change, m_code, m_id, m_alarm_left, m_idle;
  int m_price [N_PROD];
  int m_stock [N_PROD];
  bit m_alarm, m_coin_rej, m_disp, m_chg_v;

  always @(posedge clk) begin : model
    int  p, s, code;
    bit  took, refund, sold, was_credit, expired;
    m_coin_rej = 0; m_disp = 0; m_chg_v = 0;
    if (reset) begin
      m_state = S_CLOSED; m_credit = 0; m_sales = 0; m_change = 0; m_code = 0; m_id = 0;
      m_alarm = 0; m_alarm_left = 0; m_idle = 0;
      for (int i = 0; i < N_PROD; i++) begin m_price[i] = 0; m_stock[i] = INIT_STOCK; end
    end else begin
      took = 0; refund = 0; sold = 0; code = 0;
      p = (int'(sel) < N_PROD) ? m_price[sel] : 0;
      s = (int'(sel) < N_PROD) ? m_stock[sel] : 0;
      was_credit = (m_state == S_CREDIT);
      case (m_state)
        S_CLOSED: if (open_in) m_state = S_IDLE;
        S_IDLE, S_CREDIT: begin
          expired = was_credit && (m_idle + 1 >= TIMEOUT);
          if (!open_in) begin refund = 1; m_state = S_CLOSED; end
          else if (cancel || expired) begin refund = 1; m_state = S_IDLE; end
          else if (confirm) begin
            if (p == 0) code = 1;
            else if (s == 0) code = 2;
            else if (m_credit < p) code = 3;
            else begin
              sold = 1; m_state = S_DISP; m_disp = 1; m_id = int'(sel);
              m_chg_v = 1; m_change = m_credit - p; m_credit = 0;
            end
          end else if (coin_valid && m_credit + int'(coin_value) <= VMAX) begin
            took = 1; m_credit += int'(coin_value); m_state = S_CREDIT;
          end
        end
        S_DISP: m_state = open_in ? S_IDLE : S_CLOSED;
        S_ALARM: begin
          if (!open_in) begin refund = 1; m_alarm = 0; m_state = S_CLOSED; end
          else if (cancel) begin refund = 1; m_alarm = 0; m_state = S_IDLE; end
          else begin
            m_alarm_left--;
            if (m_alarm_left == 0) begin
              m_alarm = 0; m_state = (m_credit > 0) ? S_CREDIT : S_IDLE;
            end
          end
        end
        default: ;
      endcase
      if (code != 0) begin
        m_state = S_ALARM; m_alarm = 1; m_code = code; m_alarm_left = ALARM_CYCLES;
      end
      if (refund) begin
        if (m_credit != 0) begin m_chg_v = 1; m_change = m_credit; end
        m_credit = 0;
      end
      if (was_credit && m_state == S_CREDIT && !took) m_idle++;
      else m_idle = 0;
      m_coin_rej = coin_valid && !took;
      if (sales_clear) m_sales = 0;
      else if (sold) m_sales = (m_sales + p > SMAX) ? SMAX : m_sales + p;
      if (sold) m_stock[sel] = s - 1;
      if (restock && int'(restock_addr) < N_PROD) m_stock[restock_addr] = STOCK_MAX;
      if (price_we && int'(price_addr) < N_PROD) m_price[price_addr] = int'(price_data);
    end
  end

  always @(negedge clk) begin : compare
    if (check_en) begin
      chk("state", state, m_state);
      chk("credit", credit, m_credit);
      chk("coin_reject", coin_reject, m_coin_rej);
      chk("dispense_valid", dispense_valid, m_disp);
      chk("dispense_id", dispense_id, m_id);
      chk("change_valid", change_valid, m_chg_v);
      chk("change_amount", change_amount, m_change);
      chk("alarm", alarm, m_alarm);
      chk("alarm_code", alarm_code, m_code);
      chk("sales_total", sales_total, m_sales);
    end
  end

  task automatic step(); @(negedge clk); endtask

  task automatic put_coin(input int v);
    coin_valid = 1'b1; coin_value = VAL_W'(v); step(); coin_valid = 1'b0;
  endtask

  task automatic buy(input int s);
    sel = SEL_W'(s); confirm = 1'b1; step(); confirm = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1; step(); cancel = 1'b0;
  endtask

  task automatic set_price(input int a, input int v);
    price_we = 1'b1; price_addr = SEL_W'(a); price_data = VAL_W'(v); step(); price_we = 1'b0;
  endtask

  int coin_tab [8] = '{1, 5, 10, 20, 25, 50, 100, 200};

  initial begin
    int k;
    reset = 1'b1;
    step();
    check_en = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("lit_reset_state", state, S_CLOSED);
    chk("lit_reset_sales", sales_total, 0);
    put_coin(10);
    chk("lit_closed_reject", coin_reject, 1);
    open_in = 1'b1; step();
    chk("lit_open_idle", state, S_IDLE);

    // Basic purchase with change.
    set_price(2, 15);
    put_coin(10); put_coin(10);
    chk("lit_credit20", credit, 20);
    buy(2);
    chk("lit_disp", dispense_valid, 1);
    chk("lit_disp_id", dispense_id, 2);
    chk("lit_change5", change_amount, 5);
    chk("lit_sales15", sales_total, 15);
    step();
    chk("lit_back_idle", state, S_IDLE);

    // Insufficient credit alarm lasts exactly ALARM_CYCLES, credit retained.
    put_coin(10);
    buy(2);
    chk("lit_alarm_code3", alarm_code, 3);
    repeat (ALARM_CYCLES - 1) step();
    chk("lit_alarm_still", alarm, 1);
    step();
    chk("lit_alarm_gone", alarm, 0);
    chk("lit_after_alarm_state", state, S_CREDIT);
    do_cancel();
    chk("lit_cancel10", change_amount, 10);

    // Sell out product 2, then restock.
    repeat (4) begin put_coin(15); buy(2); chk("lit_sale_ok", dispense_valid, 1); step(); end
    put_coin(15); buy(2);
    chk("lit_soldout", alarm_code, 2);
    do_cancel();
    chk("lit_soldout_refund", change_amount, 15);
    restock = 1'b1; restock_addr = 3'd2; step(); restock = 1'b0;
    put_coin(15); buy(2);
    chk("lit_restock_sale", dispense_valid, 1);
    chk("lit_sales90", sales_total, 90);
    step();

    // Credit overflow rejection, then idle timeout refund.
    put_coin(250); put_coin(10);
    chk("lit_ovf_reject", coin_reject, 1);
    chk("lit_ovf_credit", credit, 250);
    k = 0;
    while (!change_valid && k < TIMEOUT + 100) begin step(); k++; end
    chk("lit_timeout_latency", k, TIMEOUT - 1);
    chk("lit_timeout_refund", change_amount, 250);

    // Coin with confirm is rejected; confirm judged on prior credit.
    put_coin(10);
    coin_valid = 1'b1; coin_value = 8'd10; sel = 3'd2; confirm = 1'b1; step();
    coin_valid = 1'b0; confirm = 1'b0;
    chk("lit_same_cycle_reject", coin_reject, 1);
    chk("lit_same_cycle_code", alarm_code, 3);
    do_cancel();
    put_coin(20);
    open_in = 1'b0; step();
    chk("lit_close_refund", change_amount, 20);
    chk("lit_closed", state, S_CLOSED);
    put_coin(5);
    chk("lit_closed_reject2", coin_reject, 1);
    open_in = 1'b1; step();

    // Invalid product: zero price and out-of-range index.
    buy(3);
    chk("lit_code1_price0", alarm_code, 1);
    do_cancel();
    chk("lit_no_refund_zero", change_valid, 0);
    buy(7);
    chk("lit_code1_range", alarm_code, 1);
    do_cancel();

    // Sales saturation and clear.
    set_price(4, 100);
    put_coin(100); buy(4); step();
    chk("lit_sales190", sales_total, 190);
    put_coin(100); buy(4); step();
    chk("lit_sales_sat", sales_total, SMAX);
    sales_clear = 1'b1; step(); sales_clear = 1'b0;
    chk("lit_sales_clear", sales_total, 0);

    // Random traffic against the model.
    for (int c = 0; c < 15000; c++) begin
      reset       = ($urandom_range(999) == 0);
      open_in     = ($urandom_range(99) < 97);
      coin_valid  = ($urandom_range(99) < 25);
      coin_value  = ($urandom_range(9) == 0) ? VAL_W'($urandom) : VAL_W'(coin_tab[$urandom_range(7)]);
      confirm     = ($urandom_range(99) < 12);
      cancel      = ($urandom_range(99) < 4);
      sel         = SEL_W'($urandom_range(7));
      price_we    = ($urandom_range(99) < 3);
      price_addr  = SEL_W'($urandom_range(7));
      price_data  = VAL_W'($urandom_range(60));
      restock     = ($urandom_range(99) < 2);
      restock_addr = SEL_W'($urandom_range(7));
      sales_clear = ($urandom_range(199) == 0);
      step();
    end
    reset = 1'b0; coin_valid = 1'b0; confirm = 1'b0; cancel = 1'b0;
    price_we = 1'b0; restock = 1'b0; sales_clear = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
